// File: rtl/ccip_mmio_pkg.sv
// Shared types and constants for the CCI-P MMIO CSR responder.
// The CCI-P structs here carry only the fields the responder uses.
package ccip_mmio_pkg;

  // Register map, byte offsets
  localparam logic [17:0] CSR_DFH       = 18'h000;
  localparam logic [17:0] CSR_AFU_ID_L  = 18'h008;
  localparam logic [17:0] CSR_AFU_ID_H  = 18'h010;
  localparam logic [17:0] CSR_SCRATCH   = 18'h018;
  localparam logic [17:0] CSR_CYCLE_CNT = 18'h020;
  localparam logic [17:0] CSR_STATUS    = 18'h028;
  localparam logic [17:0] CSR_USER_BASE = 18'h040;

  // STATUS bit indices
  localparam int STS_MISALIGN = 0;
  localparam int STS_BAD_LEN  = 1;
  localparam int STS_UNMAPPED = 2;

  typedef enum logic [1:0] {
    MMIO_4B  = 2'b00,
    MMIO_8B  = 2'b01,
    MMIO_64B = 2'b10
  } t_mmio_len;

  // length is kept as raw bits so the reserved encoding 2'b11 can arrive
  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [63:0]         data;
    logic                mmioWrValid;
    logic                mmioRdValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_if_ccip_c0_Rx c0;
  } t_if_ccip_Rx;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    logic        valid;
    logic [8:0]  tid;
    logic [63:0] data;
  } t_mmio_rsp_pipe;

  // Byte-lane merge of a (possibly partial) write into a 64-bit register
  function automatic logic [63:0] mmio_merge(input logic [63:0] old_q,
                                             input logic [63:0] wdata,
                                             input logic [63:0] mask);
    return (old_q & ~mask) | (wdata & mask);
  endfunction

endpackage

// File: rtl/ccip_mmio_csr_responder_if.sv
// MMIO request/response bundle between the CCI-P shim and the AFU responder.
interface ccip_mmio_csr_responder_if;
  import ccip_mmio_pkg::*;

  t_if_ccip_Rx    ccip_rx;
  t_if_ccip_c2_Tx ccip_c2tx;

  modport master (output ccip_rx, input ccip_c2tx);
  modport slave  (input ccip_rx, output ccip_c2tx);
endinterface

// File: rtl/ccip_mmio_rsp_pipe.sv
// Fixed-latency delay line for read completions, flushed synchronously.
module ccip_mmio_rsp_pipe
  import ccip_mmio_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           flush,
  input  t_mmio_rsp_pipe din,
  output t_mmio_rsp_pipe dout
);

  t_mmio_rsp_pipe stage [DEPTH];

  // Shift one stage per cycle; a flush drops everything in flight
  always_ff @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/ccip_mmio_csr_responder.sv
// AFU-side MMIO responder: decodes C0Rx MMIO writes/reads against the
// local CSR map and returns read completions on C2Tx after RD_LATENCY.
module ccip_mmio_csr_responder
  import ccip_mmio_pkg::*;
#(
  parameter logic [63:0] DFH_VALUE    = 64'h1000_0000_0000_0000,
  parameter logic [63:0] AFU_ID_L     = 64'h0,
  parameter logic [63:0] AFU_ID_H     = 64'h0,
  parameter int          NUM_USER_CSR = 4,
  parameter int          RD_LATENCY   = 2
) (
  input  logic                      clk,
  input  logic                      SoftReset,
  ccip_mmio_csr_responder_if.slave  mmio,
  output logic [64*NUM_USER_CSR-1:0] csr_user,
  output logic [NUM_USER_CSR-1:0]   csr_user_wr,
  output logic [2:0]                err_status
);

  // Qword indices (byte offset / 8) of the map entries
  localparam logic [14:0] QW_DFH    = CSR_DFH[17:3];
  localparam logic [14:0] QW_ID_L   = CSR_AFU_ID_L[17:3];
  localparam logic [14:0] QW_ID_H   = CSR_AFU_ID_H[17:3];
  localparam logic [14:0] QW_SCR    = CSR_SCRATCH[17:3];
  localparam logic [14:0] QW_CNT    = CSR_CYCLE_CNT[17:3];
  localparam logic [14:0] QW_STATUS = CSR_STATUS[17:3];
  localparam logic [14:0] QW_USER   = CSR_USER_BASE[17:3];

  t_ccip_c0_ReqMmioHdr hdr;
  logic        wr_req, rd_req, rd_fire, wr_ok;
  logic [14:0] qw;
  logic [NUM_USER_CSR-1:0] sel_user;
  logic        mapped, err_len, err_align, err_map, acc_ok;
  logic [63:0] wmask, wdata, rd_qword, rd_data;
  logic [2:0]  err_set, sts_clr;

  logic [63:0] scratch_q, cycle_cnt_q;
  logic [2:0]  status_q;
  logic [NUM_USER_CSR-1:0][63:0] user_q;
  logic [NUM_USER_CSR-1:0]       user_wr_q;

  t_mmio_rsp_pipe rsp_in, rsp_out;
  t_if_ccip_c2_Tx c2_tx;

  assign hdr     = mmio.ccip_rx.c0.hdr;
  assign wr_req  = mmio.ccip_rx.c0.mmioWrValid;
  assign rd_req  = mmio.ccip_rx.c0.mmioRdValid;
  // A read colliding with a write is dropped
  assign rd_fire = rd_req & ~wr_req;
  assign qw      = hdr.address[15:1];

  // Decode the request: target select, error class, write lanes and read data
  always_comb begin
    sel_user = '0;
    for (int i = 0; i < NUM_USER_CSR; i++) sel_user[i] = (qw == QW_USER + 15'(i));

    rd_qword = '0;
    if      (qw == QW_DFH)    rd_qword = DFH_VALUE;
    else if (qw == QW_ID_L)   rd_qword = AFU_ID_L;
    else if (qw == QW_ID_H)   rd_qword = AFU_ID_H;
    else if (qw == QW_SCR)    rd_qword = scratch_q;
    else if (qw == QW_CNT)    rd_qword = cycle_cnt_q;
    else if (qw == QW_STATUS) rd_qword = {61'b0, status_q};
    for (int i = 0; i < NUM_USER_CSR; i++) if (sel_user[i]) rd_qword = user_q[i];

    mapped = (qw == QW_DFH) || (qw == QW_ID_L) || (qw == QW_ID_H) || (qw == QW_SCR) ||
             (qw == QW_CNT) || (qw == QW_STATUS) || (|sel_user);

    // Length is checked first, then alignment, then mapping; one bit per request
    err_len   = !((hdr.length == MMIO_4B) || (hdr.length == MMIO_8B));
    err_align = !err_len && (hdr.length == MMIO_8B) && hdr.address[0];
    err_map   = !err_len && !err_align && !mapped;
    acc_ok    = !(err_len || err_align || err_map);

    if (hdr.length == MMIO_8B) begin
      wmask = '1;
      wdata = mmio.ccip_rx.c0.data;
    end else begin
      wmask = hdr.address[0] ? {32'hFFFF_FFFF, 32'h0} : {32'h0, 32'hFFFF_FFFF};
      wdata = {mmio.ccip_rx.c0.data[31:0], mmio.ccip_rx.c0.data[31:0]};
    end

    if (!acc_ok)                    rd_data = '0;
    else if (hdr.length == MMIO_8B) rd_data = rd_qword;
    else rd_data = {32'h0, hdr.address[0] ? rd_qword[63:32] : rd_qword[31:0]};

    wr_ok = wr_req && acc_ok;

    err_set = '0;
    if (wr_req || rd_req) begin
      err_set[STS_MISALIGN] = err_align;
      err_set[STS_BAD_LEN]  = err_len;
      err_set[STS_UNMAPPED] = err_map;
    end
    if (wr_req && rd_req) err_set[STS_BAD_LEN] = 1'b1;

    sts_clr = (wr_ok && qw == QW_STATUS) ? (wdata[2:0] & wmask[2:0]) : '0;

    rsp_in       = '0;
    rsp_in.valid = rd_fire;
    rsp_in.tid   = rd_fire ? hdr.tid : '0;
    rsp_in.data  = rd_fire ? rd_data : '0;
  end

  // Register file update: RW writes, W1C status with set priority, cycle counter
  always_ff @(posedge clk) begin
    if (SoftReset) begin
      scratch_q   <= '0;
      cycle_cnt_q <= '0;
      status_q    <= '0;
      user_q      <= '0;
      user_wr_q   <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 64'd1;
      status_q    <= (status_q & ~sts_clr) | err_set;
      if (wr_ok && qw == QW_SCR) scratch_q <= mmio_merge(scratch_q, wdata, wmask);
      for (int i = 0; i < NUM_USER_CSR; i++) begin
        user_wr_q[i] <= wr_ok && sel_user[i];
        if (wr_ok && sel_user[i]) user_q[i] <= mmio_merge(user_q[i], wdata, wmask);
      end
    end
  end

  ccip_mmio_rsp_pipe #(.DEPTH(RD_LATENCY)) u_rsp_pipe (
    .clk   (clk),
    .flush (SoftReset),
    .din   (rsp_in),
    .dout  (rsp_out)
  );

  // Valid is masked during SoftReset so a read already at the pipe output
  // in the reset cycle is cancelled along with the rest of the flush
  always_comb begin
    c2_tx             = '0;
    c2_tx.mmioRdValid = rsp_out.valid & ~SoftReset;
    c2_tx.hdr.tid     = rsp_out.tid;
    c2_tx.data        = rsp_out.data;
  end

  assign mmio.ccip_c2tx = c2_tx;
  assign csr_user       = user_q;
  assign csr_user_wr    = user_wr_q;
  assign err_status     = status_q;

endmodule

// File: tb/tb_ccip_mmio_csr_responder.sv
// Directed bench for ccip_mmio_csr_responder with a byte-offset register model.
module tb_ccip_mmio_csr_responder;
  import ccip_mmio_pkg::*;

  localparam int          N    = 4;
  localparam int          LAT  = 2;
  localparam logic [63:0] DFH  = 64'h1000_0000_0000_0000;
  localparam logic [63:0] IDL  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] IDH  = 64'hFEDC_BA98_7654_3210;
  localparam logic [1:0]  L4   = 2'b00;
  localparam logic [1:0]  L8   = 2'b01;
  localparam logic [1:0]  L64  = 2'b10;

  logic clk = 1'b0;
  logic SoftReset = 1'b1;
  logic [64*N-1:0] csr_user;
  logic [N-1:0]    csr_user_wr;
  logic [2:0]      err_status;

  ccip_mmio_csr_responder_if bus();

  ccip_mmio_csr_responder #(
    .DFH_VALUE(DFH), .AFU_ID_L(IDL), .AFU_ID_H(IDH),
    .NUM_USER_CSR(N), .RD_LATENCY(LAT)
  ) dut (
    .clk         (clk),
    .SoftReset   (SoftReset),
    .mmio        (bus),
    .csr_user    (csr_user),
    .csr_user_wr (csr_user_wr),
    .err_status  (err_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [8:0]  tid;
    logic [63:0] data;
  } exp_t;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  bit          m_known = 0;
  logic [63:0] m_rw [int];
  logic [2:0]  m_status;
  logic [63:0] m_cnt;
  logic [N-1:0] m_strobe;
  exp_t        exp_q[$];
  int          rsp_cnt = 0;
  logic [8:0]  last_tid;
  logic [63:0] last_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic bit m_mapped(input int qb);
    return (qb <= 40) || (qb >= 64 && qb < 64 + 8*N);
  endfunction

  function automatic logic [63:0] m_qword(input int qb);
    if (qb == 0)  return DFH;
    if (qb == 8)  return IDL;
    if (qb == 16) return IDH;
    if (qb == 24) return m_rw[24];
    if (qb == 32) return m_cnt;
    if (qb == 40) return {61'b0, m_status};
    if (qb >= 64 && qb < 64 + 8*N) return m_rw[qb];
    return 64'h0;
  endfunction

  // One clock: drive inputs, check this cycle's outputs, then advance the model
  task automatic tick(input bit rst, input bit wr, input bit rd, input logic [15:0] addr,
                      input logic [1:0] len, input logic [8:0] tid, input logic [63:0] data);
    int byte_off, qb;
    logic [2:0]  derr, err, clr;
    logic [63:0] q, rv;
    @(negedge clk);
    SoftReset = rst;
    bus.ccip_rx.c0.mmioWrValid = wr;
    bus.ccip_rx.c0.mmioRdValid = rd;
    bus.ccip_rx.c0.hdr.address = addr;
    bus.ccip_rx.c0.hdr.length  = len;
    bus.ccip_rx.c0.hdr.tid     = tid;
    bus.ccip_rx.c0.data        = data;
    #1;
    if (m_known) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        if (rst) chk("rsp_valid_in_reset", 64'(bus.ccip_c2tx.mmioRdValid), 64'd0);
        else begin
          chk("rsp_valid", 64'(bus.ccip_c2tx.mmioRdValid), 64'd1);
          chk("rsp_tid", 64'(bus.ccip_c2tx.hdr.tid), 64'(exp_q[0].tid));
          chk("rsp_data", bus.ccip_c2tx.data, exp_q[0].data);
        end
        void'(exp_q.pop_front());
      end else chk("rsp_idle", 64'(bus.ccip_c2tx.mmioRdValid), 64'd0);
      chk("err_status", 64'(err_status), 64'(m_status));
      chk("csr_user_wr", 64'(csr_user_wr), 64'(m_strobe));
      for (int i = 0; i < N; i++) chk($sformatf("csr_user%0d", i), csr_user[64*i +: 64], m_rw[64+8*i]);
    end
    if (bus.ccip_c2tx.mmioRdValid === 1'b1) begin
      rsp_cnt++;
      last_tid  = bus.ccip_c2tx.hdr.tid;
      last_data = bus.ccip_c2tx.data;
    end
    if (rst) begin
      m_known = 1;
      m_status = '0;
      m_cnt = '0;
      m_strobe = '0;
      m_rw[24] = '0;
      for (int i = 0; i < N; i++) m_rw[64+8*i] = '0;
      exp_q.delete();
    end else begin
      byte_off = int'(addr) * 4;
      qb = byte_off - (byte_off % 8);
      derr = '0;
      if (wr || rd) begin
        if (len != L4 && len != L8)             derr[1] = 1'b1;
        else if (len == L8 && byte_off % 8 != 0) derr[0] = 1'b1;
        else if (!m_mapped(qb))                  derr[2] = 1'b1;
      end
      err = derr;
      if (wr && rd) err[1] = 1'b1;
      if (rd && !wr) begin
        rv = '0;
        if (derr == 3'b000) begin
          q  = m_qword(qb);
          rv = (len == L8) ? q : ((q >> (8 * (byte_off % 8))) & 64'hFFFF_FFFF);
        end
        exp_q.push_back('{due: cyc + LAT, tid: tid, data: rv});
      end
      m_strobe = '0;
      clr = '0;
      if (wr && derr == 3'b000) begin
        q = m_qword(qb);
        if (len == L8) q = data;
        else if (byte_off % 8 == 0) q[31:0] = data[31:0];
        else q[63:32] = data[31:0];
        if (qb == 24) m_rw[24] = q;
        else if (qb >= 64 && qb < 64 + 8*N) begin
          m_rw[qb] = q;
          m_strobe[(qb - 64) / 8] = 1'b1;
        end else if (qb == 40 && (len == L8 || byte_off % 8 == 0)) clr = data[2:0];
      end
      m_status = (m_status & ~clr) | err;
      m_cnt = m_cnt + 64'd1;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 16'h0, L8, 9'h0, 64'h0);
  endtask
  task automatic wr(input logic [15:0] a, input logic [1:0] l, input logic [63:0] d);
    tick(0, 1, 0, a, l, 9'h0, d);
  endtask
  task automatic rd(input logic [15:0] a, input logic [1:0] l, input logic [8:0] t);
    tick(0, 0, 1, a, l, t, 64'h0);
  endtask

  int saved_cnt;

  initial begin
    bus.ccip_rx = '0;
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 16'h0, L8, 9'h0, 64'h0);

    // DFH and AFU ID reads
    rd(16'h0, L8, 9'h05);
    idle(3);
    chk("dfh_tid", 64'(last_tid), 64'h05);
    chk("dfh_data", last_data, 64'h1000_0000_0000_0000);
    rd(16'h2, L8, 9'h06);
    rd(16'h4, L8, 9'h07);
    rd(16'h5, L4, 9'h08);
    idle(3);

    // SCRATCH full and half writes
    wr(16'h6, L8, 64'hDEAD_BEEF_CAFE_F00D);
    rd(16'h6, L8, 9'h10);
    idle(3);
    chk("scratch_8b", last_data, 64'hDEAD_BEEF_CAFE_F00D);
    wr(16'h7, L4, 64'h0000_0000_1234_5678);
    rd(16'h6, L8, 9'h11);
    idle(3);
    chk("scratch_4b_hi", last_data, 64'h1234_5678_CAFE_F00D);
    rd(16'h6, L4, 9'h12);
    rd(16'h7, L4, 9'h13);
    idle(3);
    chk("scratch_rd_hi_dw", last_data, 64'h0000_0000_1234_5678);

    // Misaligned read, W1C clear, set-beats-clear on collision
    rd(16'h3, L8, 9'h14);
    #1 chk("sts_misalign", 64'(err_status), 64'h1);
    idle(3);
    chk("misalign_data", last_data, 64'h0);
    wr(16'hA, L8, 64'h1);
    #1 chk("sts_w1c", 64'(err_status), 64'h0);
    rd(16'h6, L64, 9'h15);
    #1 chk("sts_bad_len", 64'(err_status), 64'h2);
    idle(3);
    chk("bad_len_data", last_data, 64'h0);
    tick(0, 1, 1, 16'hA, L8, 9'h16, 64'h2);
    #1 chk("sts_set_wins", 64'(err_status), 64'h2);
    wr(16'hA, L8, 64'h7);
    idle(2);

    // User CSRs: writes then back-to-back reads
    wr(16'h10, L8, 64'h11);
    wr(16'h12, L8, 64'h22);
    wr(16'h14, L8, 64'h33);
    wr(16'h16, L8, 64'h44);
    rd(16'h10, L8, 9'h1);
    rd(16'h12, L8, 9'h2);
    rd(16'h14, L8, 9'h3);
    rd(16'h16, L8, 9'h4);
    idle(3);
    chk("user_last_tid", 64'(last_tid), 64'h4);
    chk("user_last_data", last_data, 64'h44);
    wr(16'h13, L4, 64'hAAAA_5555);
    rd(16'h12, L8, 9'h17);
    rd(16'h8, L8, 9'h18);
    idle(3);

    // Unmapped accesses and RO write
    rd(16'h40, L8, 9'h19);
    #1 chk("sts_unmapped", 64'(err_status), 64'h4);
    wr(16'hC, L8, 64'h55);
    wr(16'h0, L8, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(16'h0, L8, 9'h1A);
    wr(16'hA, L4, 64'h4);
    wr(16'hB, L4, 64'h7);
    idle(3);
    chk("ro_write_ignored", last_data, DFH);

    // SoftReset flushes in-flight reads and clears state
    wr(16'h6, L8, 64'h1234);
    saved_cnt = rsp_cnt;
    rd(16'h6, L8, 9'h1B);
    rd(16'h8, L8, 9'h1C);
    tick(1, 0, 1, 16'h6, L8, 9'h1D, 64'h0);
    idle(4);
    chk("no_rsp_after_reset", 64'(rsp_cnt), 64'(saved_cnt));
    tick(1, 0, 0, 16'h0, L8, 9'h0, 64'h0);
    rd(16'h8, L8, 9'h1E);
    idle(3);
    chk("cycle_cnt_restart", last_data, 64'h0);
    rd(16'h6, L8, 9'h1F);
    idle(3);
    chk("scratch_after_reset", last_data, 64'h0);
    rd(16'h8, L8, 9'h20);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
